// File: rtl/conv_seq_if.sv
// conv_seq_if: stream and datapath bus of the convolution sequencer.
//   Weight stream   : k_valid, k_data (in to sequencer), k_ready (out)
//   Pixel stream    : px_valid, px_data (in), px_ready (out)
//   kernel_reg port : kr_wr_en, kr_addr, kr_data (out)
//   LineBuffer port : lb_wr_en, lb_wr_row, lb_wr_col, lb_wr_data, lb_shift (out)
//   convolve port   : conv_start (out), conv_done (in)
// master = sequencer side, slave = sources/datapath side.
interface conv_seq_if #(
    parameter int BIT_DEPTH = 8
);
    logic                 k_valid;
    logic [BIT_DEPTH-1:0] k_data;
    logic                 k_ready;
    logic                 px_valid;
    logic [BIT_DEPTH-1:0] px_data;
    logic                 px_ready;
    logic                 kr_wr_en;
    logic [3:0]           kr_addr;
    logic [BIT_DEPTH-1:0] kr_data;
    logic                 lb_wr_en;
    logic [1:0]           lb_wr_row;
    logic [4:0]           lb_wr_col;
    logic [BIT_DEPTH-1:0] lb_wr_data;
    logic                 lb_shift;
    logic                 conv_start;
    logic                 conv_done;

    modport master (
        input  k_valid, k_data, px_valid, px_data, conv_done,
        output k_ready, px_ready, kr_wr_en, kr_addr, kr_data,
               lb_wr_en, lb_wr_row, lb_wr_col, lb_wr_data, lb_shift, conv_start
    );

    modport slave (
        output k_valid, k_data, px_valid, px_data, conv_done,
        input  k_ready, px_ready, kr_wr_en, kr_addr, kr_data,
               lb_wr_en, lb_wr_row, lb_wr_col, lb_wr_data, lb_shift, conv_start
    );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer: loads the 3x3 kernel, fills the 3-row LineBuffer, then runs
// convolve once per output row, refilling `stride` rows between passes.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      begin one image (sampled in IDLE only)
//   stride     conv stride, latched on accepted start (2 -> 2, else 1)
//   bus        conv_seq_if.master: weight/pixel streams, kernel_reg,
//              LineBuffer and convolve ports
//   out_row    output row currently in flight
//   busy       high in every state except IDLE
//   done       one-cycle pulse at end of image
// All outputs are registered.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_K | accepting KERNEL_SIZE^2 weights
// FILL   | raster fill of LineBuffer rows 0..2
// CONV   | issue conv_start
// WAIT   | waiting for conv_done
// SHIFT  | issue lb_shift
// REFILL | write one new image row into LineBuffer row 2
// FIN    | issue done
module conv_sequencer #(
    parameter int BIT_DEPTH   = 8,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int KERNEL_SIZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       stride,
    conv_seq_if.master       bus,
    output logic [4:0]       out_row,
    output logic             busy,
    output logic             done
);
    localparam logic [3:0] LAST_K   = 4'(KERNEL_SIZE * KERNEL_SIZE - 1);
    localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
    localparam logic [1:0] LAST_ROW = 2'(KERNEL_SIZE - 1);
    localparam logic [4:0] LAST_OUT_S1 = 5'((IMG_H - KERNEL_SIZE) / 1);
    localparam logic [4:0] LAST_OUT_S2 = 5'((IMG_H - KERNEL_SIZE) / 2);

    typedef enum logic [2:0] {IDLE, LOAD_K, FILL, CONV, WAIT, SHIFT, REFILL, FIN} state_t;
    state_t state, state_nxt;

    logic [3:0]           k_cnt, k_cnt_nxt;
    logic [4:0]           col, col_nxt;
    logic [1:0]           row, row_nxt;
    logic [1:0]           rows_left, rows_left_nxt;
    logic [1:0]           stride_l, stride_l_nxt;
    logic [4:0]           out_row_nxt;
    logic                 kr_wr_en_q, kr_wr_en_nxt;
    logic [3:0]           kr_addr_q, kr_addr_nxt;
    logic [BIT_DEPTH-1:0] kr_data_q, kr_data_nxt;
    logic                 lb_wr_en_q, lb_wr_en_nxt;
    logic [1:0]           lb_wr_row_q, lb_wr_row_nxt;
    logic [4:0]           lb_wr_col_q, lb_wr_col_nxt;
    logic [BIT_DEPTH-1:0] lb_wr_data_q, lb_wr_data_nxt;
    logic                 k_ready_q, px_ready_q, lb_shift_q, conv_start_q;
    logic                 k_hs, px_hs;
    logic [4:0]           last_out_row;

    // ready outputs are registered copies of the state, so the handshake
    // only fires while the FSM is in the matching load state
    assign k_hs  = bus.k_valid  & k_ready_q;
    assign px_hs = bus.px_valid & px_ready_q;
    assign last_out_row = (stride_l == 2'd2) ? LAST_OUT_S2 : LAST_OUT_S1;

    assign bus.k_ready    = k_ready_q;
    assign bus.px_ready   = px_ready_q;
    assign bus.kr_wr_en   = kr_wr_en_q;
    assign bus.kr_addr    = kr_addr_q;
    assign bus.kr_data    = kr_data_q;
    assign bus.lb_wr_en   = lb_wr_en_q;
    assign bus.lb_wr_row  = lb_wr_row_q;
    assign bus.lb_wr_col  = lb_wr_col_q;
    assign bus.lb_wr_data = lb_wr_data_q;
    assign bus.lb_shift   = lb_shift_q;
    assign bus.conv_start = conv_start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            k_cnt        <= '0;
            col          <= '0;
            row          <= '0;
            rows_left    <= '0;
            stride_l     <= '0;
            out_row      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            k_ready_q    <= 1'b0;
            px_ready_q   <= 1'b0;
            kr_wr_en_q   <= 1'b0;
            kr_addr_q    <= '0;
            kr_data_q    <= '0;
            lb_wr_en_q   <= 1'b0;
            lb_wr_row_q  <= '0;
            lb_wr_col_q  <= '0;
            lb_wr_data_q <= '0;
            lb_shift_q   <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            k_cnt        <= k_cnt_nxt;
            col          <= col_nxt;
            row          <= row_nxt;
            rows_left    <= rows_left_nxt;
            stride_l     <= stride_l_nxt;
            out_row      <= out_row_nxt;
            busy         <= (state_nxt != IDLE);
            done         <= (state == FIN);
            k_ready_q    <= (state_nxt == LOAD_K);
            px_ready_q   <= (state_nxt == FILL) || (state_nxt == REFILL);
            kr_wr_en_q   <= kr_wr_en_nxt;
            kr_addr_q    <= kr_addr_nxt;
            kr_data_q    <= kr_data_nxt;
            lb_wr_en_q   <= lb_wr_en_nxt;
            lb_wr_row_q  <= lb_wr_row_nxt;
            lb_wr_col_q  <= lb_wr_col_nxt;
            lb_wr_data_q <= lb_wr_data_nxt;
            lb_shift_q   <= (state == SHIFT);
            conv_start_q <= (state == CONV);
        end
    end

    always_comb begin
        state_nxt      = state;
        k_cnt_nxt      = k_cnt;
        col_nxt        = col;
        row_nxt        = row;
        rows_left_nxt  = rows_left;
        stride_l_nxt   = stride_l;
        out_row_nxt    = out_row;
        kr_wr_en_nxt   = 1'b0;
        kr_addr_nxt    = kr_addr_q;
        kr_data_nxt    = kr_data_q;
        lb_wr_en_nxt   = 1'b0;
        lb_wr_row_nxt  = lb_wr_row_q;
        lb_wr_col_nxt  = lb_wr_col_q;
        lb_wr_data_nxt = lb_wr_data_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = LOAD_K;
                    stride_l_nxt  = (stride == 2'd2) ? 2'd2 : 2'd1;
                    k_cnt_nxt     = '0;
                    col_nxt       = '0;
                    row_nxt       = '0;
                    rows_left_nxt = '0;
                    out_row_nxt   = '0;
                end
            end
            LOAD_K: begin
                if (k_hs) begin
                    kr_wr_en_nxt = 1'b1;
                    kr_addr_nxt  = k_cnt;
                    kr_data_nxt  = bus.k_data;
                    k_cnt_nxt    = k_cnt + 4'd1;
                    if (k_cnt == LAST_K) begin
                        k_cnt_nxt = '0;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (px_hs) begin
                    lb_wr_en_nxt   = 1'b1;
                    lb_wr_row_nxt  = row;
                    lb_wr_col_nxt  = col;
                    lb_wr_data_nxt = bus.px_data;
                    col_nxt        = col + 5'd1;
                    if (col == LAST_COL) begin
                        col_nxt = '0;
                        if (row == LAST_ROW) state_nxt = CONV;
                        else                 row_nxt   = row + 2'd1;
                    end
                end
            end
            CONV: state_nxt = WAIT;
            WAIT: begin
                if (bus.conv_done) begin
                    out_row_nxt = out_row + 5'd1;
                    if (out_row == last_out_row) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt     = SHIFT;
                        rows_left_nxt = stride_l;
                    end
                end
            end
            SHIFT: state_nxt = REFILL;
            REFILL: begin
                if (px_hs) begin
                    lb_wr_en_nxt   = 1'b1;
                    lb_wr_row_nxt  = LAST_ROW;
                    lb_wr_col_nxt  = col;
                    lb_wr_data_nxt = bus.px_data;
                    col_nxt        = col + 5'd1;
                    if (col == LAST_COL) begin
                        col_nxt       = '0;
                        rows_left_nxt = rows_left - 2'd1;
                        state_nxt     = (rows_left != 2'd1) ? SHIFT : CONV;
                    end
                end
            end
            FIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: randomized streams against a row/column level model of
// the image walk (which image row lands where, when convolve is launched).
module tb_conv_sequencer;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] stride = 2'd0;
    logic [4:0] out_row;
    logic       busy, done;

    conv_seq_if #(.BIT_DEPTH(BD)) bus();

    conv_sequencer #(.BIT_DEPTH(BD), .IMG_W(W), .IMG_H(H), .KERNEL_SIZE(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stride(stride),
        .bus(bus), .out_row(out_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] pix [H*W];
    logic [7:0] wts [9];
    bit  k_en = 0, px_en = 0, k_fire = 0, px_fire = 0, spur_done = 0;
    int  k_gap = 0, px_gap = 0, k_idx = 0, px_idx = 0, cd_cnt = 0;

    int kr_log[$], lb_log[$], cs_wr[$], cs_row[$], sh_wr[$];
    int n_done = 0;

    function automatic logic [39:0] out_vec();
        return {busy, done, out_row, bus.k_ready, bus.px_ready, bus.kr_wr_en, bus.kr_addr,
                bus.kr_data, bus.lb_wr_en, bus.lb_wr_row, bus.lb_wr_col, bus.lb_wr_data,
                bus.lb_shift, bus.conv_start};
    endfunction

    // weight source
    initial forever begin
        @(negedge clk);
        if (k_fire) k_idx++;
        bus.k_valid = k_en && (k_idx < 9) && ($urandom_range(99) >= k_gap);
        bus.k_data  = wts[(k_idx < 9) ? k_idx : 0];
        k_fire      = bus.k_valid && bus.k_ready && rst;
    end

    // pixel source
    initial forever begin
        @(negedge clk);
        if (px_fire) px_idx++;
        bus.px_valid = px_en && (px_idx < H*W) && ($urandom_range(99) >= px_gap);
        bus.px_data  = pix[(px_idx < H*W) ? px_idx : 0];
        px_fire      = bus.px_valid && bus.px_ready && rst;
    end

    // convolve stand-in: conv_done five cycles after each conv_start
    initial forever begin
        @(negedge clk);
        bus.conv_done = spur_done;
        if (!rst) cd_cnt = 0;
        else if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) bus.conv_done = 1'b1;
        end
        if (rst && bus.conv_start) cd_cnt = 5;
    end

    // event logger
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (bus.kr_wr_en) kr_log.push_back(int'({bus.kr_addr, bus.kr_data}));
            if (bus.lb_wr_en) lb_log.push_back(int'({bus.lb_wr_row, bus.lb_wr_col, bus.lb_wr_data}));
            if (bus.conv_start) begin
                cs_wr.push_back(lb_log.size());
                cs_row.push_back(int'(out_row));
            end
            if (bus.lb_shift) sh_wr.push_back(lb_log.size());
            if (done) n_done++;
        end
    end

    task automatic begin_image(input logic [1:0] s, input int kg, input int pg);
        @(negedge clk); #1;
        kr_log.delete(); lb_log.delete(); cs_wr.delete(); cs_row.delete(); sh_wr.delete();
        n_done = 0; k_idx = 0; px_idx = 0; k_fire = 0; px_fire = 0;
        k_gap = kg; px_gap = pg; k_en = 1; px_en = 1;
        stride = s; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk); #1;
            if (n_done > 0) begin to = 1'b0; break; end
        end
        repeat (3) @(negedge clk);
        #1;
        k_en = 0; px_en = 0;
    endtask

    task automatic new_image();
        foreach (pix[i]) pix[i] = 8'($urandom);
        foreach (wts[i]) wts[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (out_vec() !== 40'd0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", out_vec());
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_vec() !== 40'd0) begin
            bad++; $display("FAIL idle_outputs: got %h expected 0", out_vec());
        end
    endtask

    task automatic test_kernel_load();
        bit to;
        int got;
        new_image();
        foreach (wts[i]) wts[i] = 8'(i + 1);
        begin_image(2'd1, 40, 0);
        px_en = 0;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (kr_log.size() >= 9) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL kload_timeout: got %0d writes expected 9", kr_log.size()); end
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (bus.px_ready !== 1'b1 || bus.k_ready !== 1'b0) begin
            bad++; $display("FAIL kload_ready: got px=%b k=%b expected px=1 k=0", bus.px_ready, bus.k_ready);
        end
        total++;
        if (kr_log.size() != 9) begin bad++; $display("FAIL kload_count: got %0d expected 9", kr_log.size()); end
        for (int i = 0; i < 9 && i < kr_log.size(); i++) begin
            got = kr_log[i];
            total++;
            if (got != ((i << 8) | (i + 1))) begin
                bad++; $display("FAIL kload_entry%0d: got addr %0d data %0d expected addr %0d data %0d",
                                i, got >> 8, got & 255, i, i + 1);
            end
        end
        px_en = 1;
        wait_done(to);
        total++;
        if (to || n_done != 1 || kr_log.size() != 9) begin
            bad++; $display("FAIL kload_finish: got timeout=%0d done=%0d kr=%0d expected 0 1 9", to, n_done, kr_log.size());
        end
    endtask

    task automatic test_strides();
        int sc_s  [6] = '{1, 2, 0, 3, 2, 1};
        int sc_mid[6] = '{-1, -1, -1, -1, 1, 2};
        int sc_kg [6] = '{0, 0, 20, 0, 10, 0};
        int sc_pg [6] = '{0, 0, 10, 30, 10, 0};
        for (int t = 0; t < 6; t++) begin
            int s_eff, n, rows, exp_v;
            bit to;
            new_image();
            s_eff = (sc_s[t] == 2) ? 2 : 1;
            n     = (H - 3) / s_eff + 1;
            rows  = 3 + (n - 1) * s_eff;
            begin_image(2'(sc_s[t]), sc_kg[t], sc_pg[t]);
            if (sc_mid[t] >= 0) begin
                repeat (40) @(negedge clk);
                #1;
                stride = 2'(sc_mid[t]);
            end
            wait_done(to);
            total++;
            if (to) begin bad++; $display("FAIL s%0d_timeout: got no done expected done", t); end
            total++;
            if (n_done != 1) begin bad++; $display("FAIL s%0d_done: got %0d expected 1", t, n_done); end
            total++;
            if (cs_wr.size() != n) begin bad++; $display("FAIL s%0d_conv: got %0d expected %0d", t, cs_wr.size(), n); end
            total++;
            if (sh_wr.size() != (n - 1) * s_eff) begin
                bad++; $display("FAIL s%0d_shift: got %0d expected %0d", t, sh_wr.size(), (n - 1) * s_eff);
            end
            total++;
            if (lb_log.size() != rows * W) begin
                bad++; $display("FAIL s%0d_pixels: got %0d expected %0d", t, lb_log.size(), rows * W);
            end
            total++;
            if (out_row !== 5'(n) || busy !== 1'b0) begin
                bad++; $display("FAIL s%0d_end: got out_row=%0d busy=%b expected %0d 0", t, out_row, busy, n);
            end
            for (int k = 0; k < cs_wr.size() && k < n; k++) begin
                total++;
                if (cs_wr[k] != (3 + k * s_eff) * W || cs_row[k] != k) begin
                    bad++; $display("FAIL s%0d_conv%0d: got writes=%0d row=%0d expected %0d %0d",
                                    t, k, cs_wr[k], cs_row[k], (3 + k * s_eff) * W, k);
                end
            end
            for (int j = 0; j < sh_wr.size(); j++) begin
                total++;
                if (sh_wr[j] != (3 + j) * W) begin
                    bad++; $display("FAIL s%0d_shift%0d: got writes=%0d expected %0d", t, j, sh_wr[j], (3 + j) * W);
                end
            end
            for (int m = 0; m < lb_log.size() && m < rows * W; m++) begin
                exp_v = (((m / W) < 2 ? (m / W) : 2) << 13) | ((m % W) << 8) | int'(pix[m]);
                total++;
                if (lb_log[m] != exp_v) begin
                    bad++; $display("FAIL s%0d_px%0d: got %h expected %h", t, m, lb_log[m], exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        bit to;
        int target;
        new_image();
        target = $urandom_range(1, 5);
        begin_image(2'd1, 0, 0);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (sh_wr.size() >= target) begin to = 1'b0; break; end
        end
        repeat ($urandom_range(0, 20)) @(negedge clk);
        #1;
        total++;
        if (to || bus.px_ready !== 1'b1) begin
            bad++; $display("FAIL rst_refill_reach: got timeout=%0d px_ready=%b expected 0 1", to, bus.px_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (out_vec() !== 40'd0) begin bad++; $display("FAIL rst_async: got %h expected 0", out_vec()); end
        k_en = 0; px_en = 0;
        @(negedge clk); #1;
        total++;
        if (out_vec() !== 40'd0) begin bad++; $display("FAIL rst_hold: got %h expected 0", out_vec()); end
        @(negedge clk); #1;
        rst = 1'b1;
        begin_image(2'd1, 0, 0);
        wait_done(to);
        total++;
        if (to || n_done != 1 || cs_wr.size() != 26 || lb_log.size() != 784 || sh_wr.size() != 25) begin
            bad++; $display("FAIL rst_restart: got to=%0d done=%0d conv=%0d px=%0d shift=%0d expected 0 1 26 784 25",
                            to, n_done, cs_wr.size(), lb_log.size(), sh_wr.size());
        end
        total++;
        if (cs_row.size() == 0 || cs_row[0] != 0) begin
            bad++; $display("FAIL rst_restart_row: got %0d expected first out_row 0", cs_row.size() ? cs_row[0] : -1);
        end
    endtask

    task automatic test_ignored_inputs();
        bit to;
        new_image();
        begin_image(2'd1, 0, 50);
        for (int i = 0; i < 200 && kr_log.size() < 9; i++) @(negedge clk);
        #1;
        for (int i = 0; i < 30; i++) begin
            spur_done = 1'($urandom);
            start     = 1'($urandom);
            @(negedge clk); #1;
        end
        spur_done = 0; start = 0;
        total++;
        if (out_row !== 5'd0 || busy !== 1'b1 || cs_wr.size() != 0 || lb_log.size() >= 3 * W) begin
            bad++; $display("FAIL ign_fill: got out_row=%0d busy=%b conv=%0d px=%0d expected 0 1 0 <84",
                            out_row, busy, cs_wr.size(), lb_log.size());
        end
        for (int i = 0; i < 3000 && cs_wr.size() == 0; i++) @(negedge clk);
        #1;
        repeat (3) begin start = 1'b1; @(negedge clk); #1; end
        start = 1'b0;
        wait_done(to);
        total++;
        if (to || n_done != 1 || cs_wr.size() != 26 || lb_log.size() != 784) begin
            bad++; $display("FAIL ign_final: got to=%0d done=%0d conv=%0d px=%0d expected 0 1 26 784",
                            to, n_done, cs_wr.size(), lb_log.size());
        end
        total++;
        if (cs_wr.size() == 0 || cs_wr[0] != 3 * W || cs_row[0] != 0) begin
            bad++; $display("FAIL ign_first_conv: got writes=%0d expected %0d", cs_wr.size() ? cs_wr[0] : -1, 3 * W);
        end
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (n_done != 1 || busy !== 1'b0) begin
            bad++; $display("FAIL ign_idle: got done=%0d busy=%b expected 1 0", n_done, busy);
        end
    endtask

    initial begin
        bus.k_valid = 0; bus.k_data = 0; bus.px_valid = 0; bus.px_data = 0; bus.conv_done = 0;
        test_reset();
        test_kernel_load();
        test_strides();
        test_reset_mid_refill();
        test_ignored_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
